// File: rtl/cai_comp_ring_reader_pkg.sv
// Shared CAI definitions for the completion-ring reader: record layout,
// decoded record type, reader FSM states and the record address helper.
package cai_comp_ring_reader_pkg;

  localparam int unsigned COMP_OFF_TAG        = 0;
  localparam int unsigned COMP_OFF_STATUS     = 4;
  localparam int unsigned COMP_OFF_EXT_STATUS = 6;
  localparam int unsigned COMP_OFF_BYTES      = 8;
  localparam int unsigned COMP_REC_BYTES      = 16;
  localparam int unsigned COMP_FETCH_WORDS    = 3;

  typedef struct packed {
    logic [31:0] tag;
    logic [15:0] status;
    logic [15:0] ext_status;
    logic [31:0] bytes_written;
  } cai_comp_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_PRESENT = 2'd3
  } comp_state_e;

  // base + (slot * 16) + word * 4, all modulo 2^64
  function automatic logic [63:0] comp_word_addr(input logic [63:0] base,
                                                 input logic [31:0] head,
                                                 input logic [31:0] mask,
                                                 input logic [1:0]  word);
    logic [63:0] slot_off;
    logic [63:0] word_off;
    slot_off = {28'd0, head & mask, 4'd0};
    word_off = {60'd0, word, 2'd0};
    return base + slot_off + word_off;
  endfunction

endpackage

// File: rtl/cai_comp_ring_reader.sv
// Host-side completion-ring consumer: fetches 3 words per doorbelled record,
// decodes them and hands the record out on a valid/ready stream.
module cai_comp_ring_reader
  import cai_comp_ring_reader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [63:0]      comp_base,
  input  logic [31:0]      comp_ring_mask,
  input  logic             comp_doorbell,
  output logic             rd_req_valid,
  input  logic             rd_req_ready,
  output logic [63:0]      rd_req_addr,
  input  logic             rd_rsp_valid,
  input  logic [31:0]      rd_rsp_data,
  input  logic             rd_rsp_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_tag,
  output logic [15:0]      out_status,
  output logic [15:0]      out_ext_status,
  output logic [31:0]      out_bytes_written,
  output logic [31:0]      head_idx,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output logic             fetch_err
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  comp_state_e      state_q, state_d;
  logic [1:0]       word_q, word_d;
  cai_comp_rec_t    rec_q, rec_d;
  logic [31:0]      head_q, head_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;
  logic             consume;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rec_d   = rec_q;
    ferr_d  = ferr_q;
    consume = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && (pend_q != '0)) begin
          state_d = ST_REQ;
          word_d  = 2'd0;
        end
      end
      ST_REQ: begin
        if (rd_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rd_rsp_valid) begin
          if (rd_rsp_err) begin
            // faulted record is dropped but still consumed so the ring advances
            ferr_d  = 1'b1;
            consume = 1'b1;
            state_d = ST_IDLE;
          end else begin
            if (word_q == 2'd0) begin
              rec_d.tag = rd_rsp_data;
            end else if (word_q == 2'd1) begin
              rec_d.status     = rd_rsp_data[15:0];
              rec_d.ext_status = rd_rsp_data[31:16];
            end else begin
              rec_d.bytes_written = rd_rsp_data;
            end
            if (word_q < 2'd2) begin
              word_d  = word_q + 2'd1;
              state_d = ST_REQ;
            end else begin
              state_d = ST_PRESENT;
            end
          end
        end
      end
      ST_PRESENT: begin
        if (out_ready) begin
          consume = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    head_d = head_q + (consume ? 32'd1 : 32'd0);
    pend_d = pend_q;
    ovf_d  = ovf_q;
    // doorbell and consume together cancel out
    if (comp_doorbell && !consume) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + PEND_ONE;
    end else if (!comp_doorbell && consume) begin
      pend_d = pend_q - PEND_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= 2'd0;
      rec_q   <= '0;
      head_q  <= 32'd0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rec_q   <= rec_d;
      head_q  <= head_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  // address depends only on registered state and ring config held stable outside IDLE
  assign rd_req_valid      = (state_q == ST_REQ);
  assign rd_req_addr       = rd_req_valid ?
                             comp_word_addr(comp_base, head_q, comp_ring_mask, word_q) : 64'd0;
  assign out_valid         = (state_q == ST_PRESENT);
  assign out_tag           = rec_q.tag;
  assign out_status        = rec_q.status;
  assign out_ext_status    = rec_q.ext_status;
  assign out_bytes_written = rec_q.bytes_written;
  assign head_idx          = head_q;
  assign pending           = pend_q;
  assign overflow          = ovf_q;
  assign fetch_err         = ferr_q;

endmodule
